// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
package display_pkg;

    localparam int N_DIGITS = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_st_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [3:0] onehot_n(input logic [1:0] idx);
        onehot_n = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_sched_tick_gen.sv
// Slot timing for the display scan: counts clk cycles inside a digit slot
// and flags the last cycle of the slot and the blanking window.
module scan_tick_gen #(
    parameter int SCAN_DIV  = 65536,
    parameter int BLANK_CYC = 16,
    parameter int DIV_W     = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end,   // current cycle is the last one of the slot
    output logic in_blank    // the cycle after this one lies in the blanking window
);

    localparam logic [DIV_W-1:0] LAST    = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;

    assign slot_end = (cnt == LAST);
    assign cnt_nxt  = slot_end ? '0 : cnt + DIV_W'(1);

    // Looking one cycle ahead lets the top register its outputs so they line
    // up with the counter value rather than trailing it by a cycle.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_nxt < BLANK_V);
        end
    endgenerate

    // Free-running slot counter, wrapping at the slot length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/seg_scan_sched.sv
// Display scheduler: round-robin write port into a 4-digit BCD buffer and
// a blanked, time-multiplexed anode scan feeding the BCD decoder.
module seg_scan_sched
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 65536,
    parameter int BLANK_CYC = 16,
    parameter int DIV_W     = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] wr_digit0,
    input  logic [3:0] wr_val0,
    input  logic [1:0] wr_digit1,
    input  logic [3:0] wr_val1,
    output logic [1:0] ack,
    input  logic [3:0] digit_mask,
    output logic [3:0] bcd,
    output logic [3:0] an,
    output logic [1:0] scan_idx,
    output logic       frame_done
);

    logic [N_DIGITS-1:0][3:0] buffer;
    logic                     ptr;        // 1: requester 1 wins a tie
    scan_st_t                 state;

    logic       slot_end;
    logic       in_blank;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic [1:0] wdig;
    logic [3:0] wval;
    logic [1:0] idx_nxt;
    scan_st_t   st_nxt;

    scan_tick_gen #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .DIV_W     (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    // Grant selection: a requester acked this cycle sits out one cycle, ties go to ptr.
    always_comb begin
        elig = req & ~ack;
        gnt  = 2'b00;
        if (elig == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = elig;
        end
        wdig = gnt[1] ? wr_digit1 : wr_digit0;
        wval = gnt[1] ? wr_val1   : wr_val0;
    end

    // Next scan position and state; outputs are registered from these.
    always_comb begin
        idx_nxt = slot_end ? scan_idx + 2'd1 : scan_idx;
        st_nxt  = state;
        case (state)
            ST_BLANK: if (!in_blank) st_nxt = ST_DRIVE;
            ST_DRIVE: if (in_blank)  st_nxt = ST_BLANK;
            default:  st_nxt = ST_BLANK;
        endcase
    end

    // Arbiter: grant pulse, buffer write and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= 2'b00;
            ptr    <= 1'b0;
            buffer <= '0;
        end else begin
            ack <= gnt;
            if (|gnt) begin
                buffer[wdig] <= wval;
                ptr          <= gnt[0];
            end
        end
    end

    // Scan FSM with registered anode, digit index, nibble and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;
            scan_idx   <= 2'd0;
            an         <= AN_OFF;
            bcd        <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            state      <= st_nxt;
            scan_idx   <= idx_nxt;
            an         <= (st_nxt == ST_DRIVE && digit_mask[idx_nxt]) ? onehot_n(idx_nxt) : AN_OFF;
            // Reads the buffer as it stood before this edge's write, so a
            // write shows up on bcd one cycle after its ack edge.
            bcd        <= buffer[idx_nxt];
            frame_done <= slot_end && (scan_idx == 2'd3);
        end
    end

endmodule
